// File: rtl/cgra_elastic_pkg.sv
// Shared definitions for the CGRA elastic (valid/ack) channel blocks.
// Provides the default token width and the source-index tag width helper.
package cgra_elastic_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Tag width for a given input count; never narrower than one bit.
  function automatic int sel_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/elastic_rr_arbiter_if.sv
// Bundle of the NUM_IN elastic producer channels and the merged consumer channel.
// slave is the arbiter side, master is the producer/consumer environment side.
interface elastic_rr_arbiter_if
  import cgra_elastic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = 4
);

  localparam int SEL_W = sel_width(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] io_d_in;
  logic [NUM_IN-1:0]            io_v_in;
  logic [NUM_IN-1:0]            io_a_in;
  logic [DATA_WIDTH-1:0]        io_d_out;
  logic [SEL_W-1:0]             io_sel_out;
  logic                         io_v_out;
  logic                         io_a_out;

  modport slave (
    input  io_d_in,
    input  io_v_in,
    output io_a_in,
    output io_d_out,
    output io_sel_out,
    output io_v_out,
    input  io_a_out
  );

  modport master (
    output io_d_in,
    output io_v_in,
    input  io_a_in,
    input  io_d_out,
    input  io_sel_out,
    input  io_v_out,
    output io_a_out
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate requests so ptr is at bit 0,
// take the lowest set bit, then rotate the winner index back.
module rr_priority_picker
  import cgra_elastic_pkg::*;
#(
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt_onehot,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [NUM_IN-1:0] rot_s;
  logic              found_s;
  int                first_s;
  int                win_s;

  // Rotate right by ptr; ptr < NUM_IN so a single subtraction wraps it.
  always_comb begin
    rot_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((i + int'(ptr)) >= NUM_IN) begin
        rot_s[i] = req[i + int'(ptr) - NUM_IN];
      end else begin
        rot_s[i] = req[i + int'(ptr)];
      end
    end
  end

  // Priority encode, lowest rotated position wins.
  always_comb begin
    found_s = 1'b0;
    first_s = 0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found_s = 1'b1;
        first_s = i;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Rotate the winner back to an absolute input index.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    win_s      = first_s + int'(ptr);
    if (win_s >= NUM_IN) begin
      win_s = win_s - NUM_IN;
    end else begin
      win_s = win_s;
    end
    if (found_s) begin
      gnt_idx             = SEL_W'(win_s);
      gnt_onehot[win_s]   = 1'b1;
    end else begin
      gnt_idx    = '0;
      gnt_onehot = '0;
    end
  end

  assign any = |req;

endmodule

// File: rtl/elastic_rr_arbiter.sv
// Merges NUM_IN elastic producers onto one registered elastic output slot with
// round-robin grant; each output token carries the index of its source input.
module elastic_rr_arbiter
  import cgra_elastic_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  NUM_IN     = 4,
  localparam int SEL_W      = sel_width(NUM_IN)
) (
  input  logic                clock,
  input  logic                reset,
  elastic_rr_arbiter_if.slave bus
);

  logic [SEL_W-1:0]      ptr_r;
  logic [SEL_W-1:0]      ptr_next_s;
  logic [DATA_WIDTH-1:0] d_out_r;
  logic [SEL_W-1:0]      sel_out_r;
  logic                  v_out_r;

  logic [NUM_IN-1:0]     gnt_onehot_s;
  logic [SEL_W-1:0]      gnt_idx_s;
  logic                  any_s;
  logic                  load_en_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] d_sel_s;
  logic [NUM_IN-1:0]     a_in_s;

  rr_priority_picker #(
    .NUM_IN (NUM_IN)
  ) u_picker (
    .req        (bus.io_v_in),
    .ptr        (ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  // Slot can take a token when empty or when its current token drains this cycle.
  assign load_en_s = !v_out_r || bus.io_a_out;
  assign accept_s  = load_en_s && any_s;

  // Ack only the granted producer, and never while reset holds the slot cleared.
  always_comb begin
    a_in_s = '0;
    if (!reset && accept_s) begin
      a_in_s = gnt_onehot_s;
    end else begin
      a_in_s = '0;
    end
  end

  // Select the granted token and compute the pointer just past the winner.
  always_comb begin
    d_sel_s    = bus.io_d_in[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    ptr_next_s = '0;
    if (gnt_idx_s == SEL_W'(NUM_IN - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_s + SEL_W'(1);
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r     <= '0;
      d_out_r   <= '0;
      sel_out_r <= '0;
      v_out_r   <= 1'b0;
    end else if (accept_s) begin
      d_out_r   <= d_sel_s;
      sel_out_r <= gnt_idx_s;
      v_out_r   <= 1'b1;
      ptr_r     <= ptr_next_s;
    end else if (load_en_s) begin
      // Drained with nothing to replace it: data and tag keep their last values.
      v_out_r   <= 1'b0;
    end else begin
      v_out_r   <= v_out_r;
    end
  end

  assign bus.io_a_in    = a_in_s;
  assign bus.io_d_out   = d_out_r;
  assign bus.io_sel_out = sel_out_r;
  assign bus.io_v_out   = v_out_r;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Self-checking bench for elastic_rr_arbiter (DATA_WIDTH=8, NUM_IN=4): vector table,
// hand-written reset/backpressure sequences and a random scoreboard run.
module tb_elastic_rr_arbiter;

  localparam int DW = 8;
  localparam int NI = 4;

  logic clk;
  logic rst;

  elastic_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) bus ();

  elastic_rr_arbiter #(.DATA_WIDTH(DW), .NUM_IN(NI)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] v;
    logic       a;
    logic [3:0] ea;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] es;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] sel;
  } tok_t;

  vec_t tbl [14];
  tok_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NI; k++) begin
      if (v[(ptr + k) % NI]) return (ptr + k) % NI;
    end
    return -1;
  endfunction

  task automatic set_data_inc();
    for (int i = 0; i < NI; i++) bus.io_d_in[i*DW +: DW] = 8'h10 + 8'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.io_v_in = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle at negedge, check the ack before the edge and the slot after it.
  task automatic step(input string tag, input logic [3:0] v, input logic a, input logic [3:0] ea,
                      input logic ev, input logic [7:0] ed, input logic [1:0] es);
    @(negedge clk);
    bus.io_v_in  = v;
    bus.io_a_out = a;
    #1;
    chk({tag, "_a_in"}, 32'(bus.io_a_in), 32'(ea));
    @(posedge clk);
    #1;
    chk({tag, "_v_out"}, 32'(bus.io_v_out), 32'(ev));
    chk({tag, "_d_out"}, 32'(bus.io_d_out), 32'(ed));
    chk({tag, "_sel_out"}, 32'(bus.io_sel_out), 32'(es));
  endtask

  logic [3:0] pend;
  logic [7:0] tok [NI];
  logic [5:0] cnt [NI];
  int         wait_cnt [NI];
  int         m_ptr;
  logic       m_v;

  initial begin
    rst          = 1'b1;
    bus.io_v_in  = 4'b1111;
    bus.io_a_out = 1'b1;
    set_data_inc();

    // Reset held with every producer valid: nothing acked, slot empty.
    @(negedge clk);
    #1;
    chk("rst_v_out", 32'(bus.io_v_out), 32'd0);
    chk("rst_a_in", 32'(bus.io_a_in), 32'd0);
    chk("rst_d_out", 32'(bus.io_d_out), 32'd0);
    chk("rst_sel_out", 32'(bus.io_sel_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_a_in", 32'(bus.io_a_in), 32'b0001);
    @(posedge clk);
    #1;
    chk("rel_v_out", 32'(bus.io_v_out), 32'd1);
    chk("rel_sel_out", 32'(bus.io_sel_out), 32'd0);
    chk("rel_d_out", 32'(bus.io_d_out), 32'h10);

    // Table: rotation, sparse/wrap fairness, drain, idle and backpressure.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[5]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[7]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    do_reset();
    for (int r = 0; r < 14; r++) begin
      step($sformatf("tbl%0d", r), tbl[r].v, tbl[r].a, tbl[r].ea, tbl[r].ev, tbl[r].ed, tbl[r].es);
    end

    // Backpressure: slot held for three cycles, then reload without a bubble.
    do_reset();
    bus.io_d_in[1*DW +: DW] = 8'hA5;
    step("bp_load", 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd1);
    bus.io_d_in[1*DW +: DW] = 8'h5A;
    for (int c = 0; c < 3; c++) step($sformatf("bp_hold%0d", c), 4'b0010, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd1);
    step("bp_resume", 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1);

    // Asynchronous reset between edges while the slot is full.
    do_reset();
    set_data_inc();
    step("ar0", 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0);
    step("ar1", 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    step("ar2", 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_v_out", 32'(bus.io_v_out), 32'd0);
    chk("ar_a_in", 32'(bus.io_a_in), 32'd0);
    chk("ar_d_out", 32'(bus.io_d_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rel_a_in", 32'(bus.io_a_in), 32'b0001);
    @(posedge clk);
    #1;
    chk("ar_rel_sel", 32'(bus.io_sel_out), 32'd0);
    chk("ar_rel_d", 32'(bus.io_d_out), 32'h10);

    // Random producers hold valid until acked; expected tokens go through the scoreboard.
    do_reset();
    pend  = 4'b0000;
    m_ptr = 0;
    m_v   = 1'b0;
    sb.delete();
    for (int i = 0; i < NI; i++) begin
      cnt[i]      = 6'd0;
      wait_cnt[i] = 0;
      tok[i]      = 8'h00;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int   g;
      logic le;
      logic [3:0] ea;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 60)) begin
          pend[i] = 1'b1;
          tok[i]  = {2'(i), cnt[i]};
        end
        bus.io_d_in[i*DW +: DW] = tok[i];
      end
      bus.io_v_in  = pend;
      bus.io_a_out = ($urandom_range(0, 99) < 70);
      #1;
      le = !m_v || bus.io_a_out;
      g  = le ? ref_pick(pend, m_ptr) : -1;
      ea = (g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("rnd_a_in", 32'(bus.io_a_in), 32'(ea));
      chk("rnd_a_in_valid", 32'((bus.io_a_in & ~pend) == 4'b0000 && $onehot0(bus.io_a_in)), 32'd1);
      chk("rnd_v_out", 32'(bus.io_v_out), 32'(m_v));
      if (bus.io_v_out && bus.io_a_out) begin
        if (sb.size() == 0) begin
          chk("rnd_dup_token", 32'(sb.size()), 32'd1);
        end else begin
          tok_t e;
          e = sb.pop_front();
          chk("rnd_d_out", 32'(bus.io_d_out), 32'(e.d));
          chk("rnd_sel_out", 32'(bus.io_sel_out), 32'(e.sel));
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (pend[i] && g == i) begin
          chk("rnd_fair_wait", 32'(wait_cnt[i] <= NI - 1), 32'd1);
          wait_cnt[i] = 0;
        end else if (pend[i] && g >= 0) begin
          wait_cnt[i]++;
        end else if (!pend[i]) begin
          wait_cnt[i] = 0;
        end
      end
      if (g >= 0) begin
        sb.push_back('{tok[g], 2'(g)});
        pend[g] = 1'b0;
        cnt[g]  = cnt[g] + 6'd1;
        m_v     = 1'b1;
        m_ptr   = (g + 1) % NI;
      end else if (le) begin
        m_v = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    chk("rnd_sb_residue", 32'(sb.size()), 32'(m_v));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
